uart_io_unit: RTL and testbench

- Byte-level UART I/O engine that serves the core's SENDB/RECVB instructions.
- Accepts the controller's one-cycle `uart_go` request, qualified by `rors` (1 = send, 0 = receive).
- Serialises and deserialises 8N1 frames on `txd`/`rxd`; received bytes are buffered in a small FIFO.
- Returns a one-cycle `uart_done` pulse, on which the controller leaves its busy-wait state; on receive, `rx_byte` then supplies register write-back data.

---
 rtl/uart_io_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_io_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_unit.sv
// rtl/uart_io_unit.sv - byte-level 8N1 UART engine serving SENDB/RECVB requests
module uart_io_unit #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_go,
    input  logic       rors,
    input  logic [7:0] tx_byte,
    output logic       uart_done,
    output logic [7:0] rx_byte,
    output logic       txd,
    input  logic       rxd,
    output logic       busy,
    output logic       rx_overflow,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {RQ_IDLE, RQ_WAIT, RQ_DONE} rq_state_t;

    tx_state_t        r_tx_state, w_tx_next;
    rx_state_t        r_rx_state, w_rx_next;
    rq_state_t        r_rq_state, w_rq_next;

    logic [7:0]       r_tx_shift;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic             r_txd;
    logic             w_txd_next;
    logic             w_tx_tick;
    logic             w_tx_busy;
    logic             w_tx_done;

    logic             r_rxd_s1, r_rxd_s2, r_rxd_d;
    logic [7:0]       r_rx_shift;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic             w_rx_tick;
    logic             w_push;
    logic             w_bad_stop;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full, w_empty;
    logic             w_pop, w_do_push, w_drop;

    logic [7:0]       r_rx_byte;
    logic             r_overflow, r_frame_err;
    logic             w_accept;

    // A request is taken only when both request paths sit idle; a go in a done
    // cycle is ignored so that uart_done can never stretch over two cycles.
    assign w_accept  = uart_go && (r_tx_state == TX_IDLE) && (r_rq_state == RQ_IDLE);
    assign w_tx_tick = (r_tx_cnt == '0);
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);

    // TX state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // TX next-state: start, eight data bits, stop, one done cycle
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_accept && rors) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_DONE;
            TX_DONE:  w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: the line level for the coming cycle is computed here and registered
    always_comb begin
        w_tx_busy  = (r_tx_state == TX_START) || (r_tx_state == TX_DATA) || (r_tx_state == TX_STOP);
        w_tx_done  = (r_tx_state == TX_DONE);
        w_txd_next = 1'b1;
        case (w_tx_next)
            TX_START: w_txd_next = 1'b0;
            TX_DATA:  w_txd_next = (r_tx_state == TX_DATA && w_tx_tick) ? r_tx_shift[1] : r_tx_shift[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    // TX datapath: byte latch, bit-period down-counter, shift register, line flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_txd_next;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_next == TX_START) begin
                        r_tx_shift <= tx_byte;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_bit   <= '0;
                    end
                end
                TX_START, TX_STOP: r_tx_cnt <= w_tx_tick ? BIT_LAST : r_tx_cnt - CNT_ONE;
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end else begin
                        r_tx_cnt   <= r_tx_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // rxd synchroniser plus one delayed copy for falling-edge detection; resets to idle-high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_d  <= 1'b1;
        end else begin
            r_rxd_s1 <= rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // RX next-state: falling edge, mid-start re-check, eight samples, stop sample
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rxd_d && !r_rxd_s2) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: stop-bit verdict
    always_comb begin
        w_push     = (r_rx_state == RX_STOP) && w_rx_tick && r_rxd_s2;
        w_bad_stop = (r_rx_state == RX_STOP) && w_rx_tick && !r_rxd_s2;
    end

    // RX datapath: idle preloads the half-bit wait, then full-bit sampling LSB first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= HALF_LAST;
                    r_rx_bit <= '0;
                end
                RX_START, RX_STOP: r_rx_cnt <= w_rx_tick ? BIT_LAST : r_rx_cnt - CNT_ONE;
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= BIT_LAST;
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
                    end else begin
                        r_rx_cnt   <= r_rx_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // A push into a full FIFO survives only when a pop frees a slot in the same cycle
    assign w_do_push = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Request state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rq_state <= RQ_IDLE;
        else       r_rq_state <= w_rq_next;
    end

    // Request next-state: occupancy is judged on the registered count at go
    always_comb begin
        w_rq_next = r_rq_state;
        case (r_rq_state)
            RQ_IDLE: if (w_accept && !rors) w_rq_next = w_empty ? RQ_WAIT : RQ_DONE;
            RQ_WAIT: if (!w_empty) w_rq_next = RQ_DONE;
            RQ_DONE: w_rq_next = RQ_IDLE;
            default: w_rq_next = RQ_IDLE;
        endcase
    end

    // Request outputs: pop on a hit at go, or on the first non-empty cycle while waiting
    always_comb begin
        w_pop = ((r_rq_state == RQ_IDLE) && w_accept && !rors && !w_empty) ||
                ((r_rq_state == RQ_WAIT) && !w_empty);
    end

    // Delivered byte and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_byte   <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_pop) r_rx_byte <= r_mem[r_rd_ptr];
            if (w_drop) r_overflow <= 1'b1;
            if (w_bad_stop) r_frame_err <= 1'b1;
        end
    end

    assign uart_done    = w_tx_done || (r_rq_state == RQ_DONE);
    assign busy         = w_tx_busy || (r_rq_state == RQ_WAIT);
    assign txd          = r_txd;
    assign rx_byte      = r_rx_byte;
    assign rx_overflow  = r_overflow;
    assign rx_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_io_unit.sv
// tb/tb_uart_io_unit.sv - randomized self-checking bench for uart_io_unit
module tb_uart_io_unit;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int RX_DONE_LAT = 2 + CPB / 2 + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       uart_go = 1'b0;
    logic       rors = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rxd = 1'b1;
    logic       uart_done;
    logic [7:0] rx_byte;
    logic       txd;
    logic       busy;
    logic       rx_overflow;
    logic       rx_frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;

    uart_io_unit #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .uart_go(uart_go), .rors(rors), .tx_byte(tx_byte),
        .uart_done(uart_done), .rx_byte(rx_byte), .txd(txd), .rxd(rxd), .busy(busy),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of an 8N1 frame at bit position i (0 = start, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic do_send(input logic [7:0] b, input bit poke);
        logic exp_txd;
        uart_go = 1'b1; rors = 1'b1; tx_byte = b;
        for (int k = 1; k <= 10 * CPB + 2; k++) begin
            tick();
            if (k == 1) begin uart_go = 1'b0; tx_byte = 8'($urandom); end
            if (poke && k == 40) begin uart_go = 1'b1; rors = 1'($urandom); tx_byte = ~b; end
            if (poke && k == 41) uart_go = 1'b0;
            exp_txd = (k <= 10 * CPB) ? frame_bit(b, (k - 1) / CPB) : 1'b1;
            chk("tx_txd", {31'd0, txd}, {31'd0, exp_txd});
            chk("tx_done", {31'd0, uart_done}, {31'd0, (k == 10 * CPB + 1)});
            chk("tx_busy", {31'd0, busy}, {31'd0, (k <= 10 * CPB)});
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 9) ? stop : frame_bit(b, i);
            repeat (CPB) tick();
        end
        rxd = 1'b1;
        repeat (4) tick();
        if (stop) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic recv_hit();
        logic [7:0] e;
        e = (q.size() > 0) ? q.pop_front() : 8'h00;
        uart_go = 1'b1; rors = 1'b0; tx_byte = 8'($urandom);
        tick();
        uart_go = 1'b0;
        chk("rx_hit_done", {31'd0, uart_done}, 32'd1);
        chk("rx_hit_byte", {24'd0, rx_byte}, {24'd0, e});
        chk("rx_hit_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rx_hit_done_once", {31'd0, uart_done}, 32'd0);
        chk("rx_hit_byte_hold", {24'd0, rx_byte}, {24'd0, e});
    endtask

    task automatic recv_wait(input logic [7:0] b);
        int c0;
        int done_at;
        int n_done;
        logic [7:0] e;
        uart_go = 1'b1; rors = 1'b0;
        tick();
        uart_go = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j == 10) begin uart_go = 1'b1; rors = 1'b1; end
            if (j == 11) uart_go = 1'b0;
            chk("rx_wait_no_done", {31'd0, uart_done}, 32'd0);
            chk("rx_wait_busy", {31'd0, busy}, 32'd1);
            chk("rx_wait_txd_idle", {31'd0, txd}, 32'd1);
            tick();
        end
        c0 = cyc;
        done_at = -1;
        n_done = 0;
        fork
            drive_frame(b, 1'b1);
            begin
                for (int n = 0; n < 120; n++) begin
                    tick();
                    if (uart_done === 1'b1) begin
                        n_done++;
                        if (done_at < 0) done_at = cyc;
                    end
                end
            end
        join
        e = (q.size() > 0) ? q.pop_front() : b;
        chk("rx_wait_done_cycle", 32'(done_at - c0), 32'(RX_DONE_LAT));
        chk("rx_wait_done_count", 32'(n_done), 32'd1);
        chk("rx_wait_byte", {24'd0, rx_byte}, {24'd0, e});
        chk("rx_wait_busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ovf"}, {31'd0, rx_overflow}, {31'd0, m_ovf});
        chk({tag, "_ferr"}, {31'd0, rx_frame_err}, {31'd0, m_ferr});
    endtask

    initial begin
        int n;
        logic [7:0] b;

        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_done", {31'd0, uart_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk_flags("rst");
        rstn = 1'b1;
        repeat (2) tick();

        do_send(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) do_send(8'($urandom), 1'b0);

        drive_frame(8'h3C, 1'b1);
        drive_frame(8'h7E, 1'b1);
        recv_hit();
        recv_hit();

        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) drive_frame(8'($urandom), 1'b1);
        for (int i = 0; i < n; i++) recv_hit();

        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (20) tick();
        chk_flags("glitch");

        recv_wait(8'h01);

        drive_frame(8'($urandom), 1'b0);
        chk_flags("frame_err");
        recv_wait(8'($urandom));

        for (int i = 0; i < 5; i++) drive_frame(8'h10 + 8'(i), 1'b1);
        chk_flags("overflow");
        for (int i = 0; i < 4; i++) recv_hit();
        recv_wait(8'($urandom));

        fork
            do_send(8'($urandom), 1'b0);
            drive_frame(8'($urandom), 1'b1);
        join
        repeat (4) tick();
        recv_hit();

        b = 8'($urandom);
        uart_go = 1'b1; rors = 1'b1; tx_byte = b;
        tick();
        uart_go = 1'b0;
        repeat (35) tick();
        chk("mid_txd_bit3", {31'd0, txd}, {31'd0, b[3]});
        #1 rstn = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, uart_done}, 32'd0);
        chk("mid_rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk_flags("mid_rst");
        repeat (2) tick();
        rstn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("post_rst_no_done", {31'd0, uart_done}, 32'd0);
            chk("post_rst_txd", {31'd0, txd}, 32'd1);
        end

        do_send(8'($urandom), 1'b0);
        recv_wait(8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
